// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down counter with programmable modulus
// (MAX_VAL+1), synchronous clear/load, count enable, wrap or saturate mode,
// one-cycle wrap pulse and sticky overflow flag.
// Optional feature macro: COUNTER_CMP_EN adds cmp_val/cmp_hit, a registered
// compare that is aligned with count.
module updown_counter_mod #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = (1 << WIDTH) - 1,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
`ifdef COUNTER_CMP_EN
    input  logic [WIDTH-1:0] cmp_val,
    output logic             cmp_hit,
`endif
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;

    // Next-state: clr beats load beats en; boundary steps wrap or hold by mode.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_set = 1'b0;
        if (clr) begin
            count_d = RESET_C;
        end else if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count_q >= MAX_C) begin
                    ovf_set = 1'b1;
                    if (SATURATE == 0) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (count_q == '0) begin
                    ovf_set = 1'b1;
                    if (SATURATE == 0) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end
        // A boundary event in the same cycle as ovf_clr keeps the flag set.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_C;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

`ifdef COUNTER_CMP_EN
    logic cmp_hit_q;

    // Compare against the next count so the hit lines up with count itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_hit_q <= 1'b0;
        end else begin
            cmp_hit_q <= (count_d == cmp_val);
        end
    end

    assign cmp_hit = cmp_hit_q;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: one wrapping instance and one
// saturating instance (WIDTH=4, MAX_VAL=9, RESET_VAL=0) share the stimulus.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up_dn, clr, load, ovf_clr;
    logic [3:0] load_val;
    logic [3:0] count_m, count_s;
    logic       wrap_m, wrap_s, ovf_m, ovf_s;
`ifdef COUNTER_CMP_EN
    logic [3:0] cmp_val;
    logic       cmp_hit_m, cmp_hit_s;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0)) dut_m (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
`ifdef COUNTER_CMP_EN
        .cmp_val(cmp_val), .cmp_hit(cmp_hit_m),
`endif
        .count(count_m), .wrap(wrap_m), .ovf(ovf_m)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RESET_VAL(0)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
`ifdef COUNTER_CMP_EN
        .cmp_val(cmp_val), .cmp_hit(cmp_hit_s),
`endif
        .count(count_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_m(input string tag, input int c, input int w, input int o);
        chk({tag, " wrap-mode count"}, int'(count_m), c);
        chk({tag, " wrap-mode wrap"},  int'(wrap_m),  w);
        chk({tag, " wrap-mode ovf"},   int'(ovf_m),   o);
    endtask

    task automatic chk_s(input string tag, input int c, input int w, input int o);
        chk({tag, " sat-mode count"}, int'(count_s), c);
        chk({tag, " sat-mode wrap"},  int'(wrap_s),  w);
        chk({tag, " sat-mode ovf"},   int'(ovf_s),   o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int up_m[12];
        int up_s[12];
        int dn_m[5];
        int dn_s[5];
        up_m = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        up_s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
        dn_m = '{2, 1, 0, 9, 8};
        dn_s = '{2, 1, 0, 0, 0};

        reset = 1'b1; en = 0; up_dn = 1; clr = 0; load = 0; ovf_clr = 0; load_val = 0;
`ifdef COUNTER_CMP_EN
        cmp_val = 4'd5;
`endif
        #12;
        chk_m("reset", 0, 0, 0);
        chk_s("reset", 0, 0, 0);
        #10 reset = 1'b0;   // released between edges at t=22

        // Count up through the terminal value.
        en = 1; up_dn = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk_m($sformatf("up step %0d", i), up_m[i], (i == 9) ? 1 : 0, (i >= 9) ? 1 : 0);
            chk_s($sformatf("up step %0d", i), up_s[i], 0, (i >= 9) ? 1 : 0);
        end

        // Load 3 then count down through zero.
        en = 0; load = 1; load_val = 4'd3;
        step();
        chk_m("load 3", 3, 0, 1);
        chk_s("load 3", 3, 0, 1);
        load = 0; en = 1; up_dn = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_m($sformatf("down step %0d", i), dn_m[i], (i == 3) ? 1 : 0, 1);
            chk_s($sformatf("down step %0d", i), dn_s[i], 0, 1);
        end

        // ovf_clr with no boundary event clears the sticky flag.
        en = 0; ovf_clr = 1;
        step();
        chk_m("ovf_clr idle", 8, 0, 0);
        chk_s("ovf_clr idle", 0, 0, 0);
        ovf_clr = 0;

        // Load is clamped to MAX_VAL; clr wins over load.
        load = 1; load_val = 4'd15;
        step();
        chk_m("load clamp", 9, 0, 0);
        chk_s("load clamp", 9, 0, 0);
        clr = 1; load_val = 4'd5; en = 1; up_dn = 1;
        step();
        chk_m("clr over load", 0, 0, 0);
        chk_s("clr over load", 0, 0, 0);
        clr = 0; load_val = 4'd9; en = 0;
        step();
        load = 0;

        // ovf_clr in the same cycle as a boundary event: set wins.
        en = 1; up_dn = 1; ovf_clr = 1;
        step();
        chk_m("ovf_clr vs wrap", 0, 1, 1);
        chk_s("ovf_clr vs sat", 9, 0, 1);
        en = 0;
        step();
        chk_m("idle after wrap", 0, 0, 0);
        chk_s("idle after sat", 9, 0, 0);
        ovf_clr = 0;

        // Direction change with no dead cycle: down from 0 wraps to 9, then up wraps to 0.
        en = 1; up_dn = 0;
        step();
        chk_m("dir down wrap", 9, 1, 1);
        chk_s("dir down", 8, 0, 0);
        up_dn = 1;
        step();
        chk_m("dir up wrap", 0, 1, 1);
        chk_s("dir up", 9, 0, 0);

        // Bring wrap-mode counter to 6, then assert reset between edges.
        for (int i = 0; i < 6; i++) step();
        chk_m("pre-reset", 6, 0, 1);
        chk_s("pre-reset", 9, 0, 1);
        #3 reset = 1'b1;
        #1;
        chk_m("async reset", 0, 0, 0);
        chk_s("async reset", 0, 0, 0);
        step();
        chk_m("reset held", 0, 0, 0);
        #2 reset = 1'b0;
        step();
        chk_m("post-reset count", 1, 0, 0);
        chk_s("post-reset count", 1, 0, 0);

`ifdef COUNTER_CMP_EN
        clr = 1;
        step();
        clr = 0;
        chk("cmp at 0", int'(cmp_hit_m), 0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk($sformatf("cmp wrap-mode count %0d", i), int'(cmp_hit_m), (i == 5) ? 1 : 0);
            chk($sformatf("cmp sat-mode count %0d", i), int'(cmp_hit_s), (i == 5) ? 1 : 0);
        end
`endif

        en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
